source_v3: RTL and testbench

SOURCE_V3 -- requirements
Module: source_v3

---
 rtl/source_v3.sv | 143 ++++++++++++++
 tb/tb_source_v3.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/source_v3.sv
// Burst source: streams length words from a DEPTH-entry buffer over a valid/ready handshake.
// Optional stall counter enabled with macro SOURCE_V3_STALL_CNT_EN.
module source_v3 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int WT = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             wr_en,
  input  logic [WT-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             start,
  input  logic [WT-1:0]    start_addr,
  input  logic [WT:0]      length,
  output logic             vaild,
  output logic [WIDTH-1:0] data_out,
  input  logic             ready,
  output logic             busy,
  output logic             done
`ifdef SOURCE_V3_STALL_CNT_EN
  , output logic [15:0]    stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [WT-1:0] ADDR_ONE = WT'(1);
  localparam logic [WT:0]   LEN_ZERO = (WT + 1)'(0);
  localparam logic [WT:0]   LEN_ONE  = (WT + 1)'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WT-1:0]    rd_addr;
  logic [WT:0]      remain;
  logic             load_first;
  logic             advance;
  logic             finish;
  logic [WIDTH-1:0] mem [DEPTH];

  // Next-state decode and datapath control strobes
  always_comb begin
    state_nxt  = state;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length != LEN_ZERO) begin
            load_first = 1'b1;
            state_nxt  = SEND;
          end else begin
            state_nxt  = DONE;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      SEND: begin
        if (vaild && ready) begin
          if (remain > LEN_ONE) begin
            advance = 1'b1;
          end else begin
            finish    = 1'b1;
            state_nxt = DONE;
          end
        end else begin
          state_nxt = SEND;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; busy/done are registered copies of the next-state decode
  always_ff @(posedge clk) begin
    if (s_rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);
      done  <= (state_nxt == DONE);
    end
  end

  // Read pointer and offered word; the fetch reads mem before this edge's write lands
  always_ff @(posedge clk) begin
    if (s_rst) begin
      vaild    <= 1'b0;
      data_out <= '0;
      rd_addr  <= '0;
      remain   <= '0;
    end else if (load_first) begin
      vaild    <= 1'b1;
      data_out <= mem[start_addr];
      rd_addr  <= start_addr + ADDR_ONE;
      remain   <= length;
    end else if (advance) begin
      data_out <= mem[rd_addr];
      rd_addr  <= rd_addr + ADDR_ONE;
      remain   <= remain - LEN_ONE;
    end else if (finish) begin
      vaild <= 1'b0;
    end
  end

  // Buffer storage, fully cleared on reset
  always_ff @(posedge clk) begin
    if (s_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

`ifdef SOURCE_V3_STALL_CNT_EN
  // Saturating count of cycles the destination held off an offered word
  always_ff @(posedge clk) begin
    if (s_rst) begin
      stall_cnt <= 16'h0000;
    end else if ((state == IDLE) && start) begin
      stall_cnt <= 16'h0000;
    end else if (vaild && !ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_source_v3.sv
// Randomized + directed bench for source_v3 against a queue-based burst model.
module tb_source_v3;
  localparam int WIDTH = 8;
  localparam int DEPTH = 256;
  localparam int WT    = 8;

  logic             clk = 1'b0;
  logic             s_rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WT-1:0]    wr_addr = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic             start = 1'b0;
  logic [WT-1:0]    start_addr = '0;
  logic [WT:0]      length = '0;
  logic             ready = 1'b0;
  logic             vaild;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic             done;
`ifdef SOURCE_V3_STALL_CNT_EN
  logic [15:0]      stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  int               m_phase;   // 0 idle, 1 offering words, 2 completion pulse
  logic             m_vaild;
  logic [WIDTH-1:0] m_data;
  int               m_stall;
  int               addr_q[$];
  logic [WIDTH-1:0] xlog[$];

  source_v3 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .s_rst(s_rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .start_addr(start_addr), .length(length),
    .vaild(vaild), .data_out(data_out), .ready(ready), .busy(busy), .done(done)
`ifdef SOURCE_V3_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    if (s_rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_phase = 0;
      m_vaild = 1'b0;
      m_data  = '0;
      m_stall = 0;
      addr_q.delete();
    end else begin
      case (m_phase)
        0: if (start) begin
          m_stall = 0;
          if (int'(length) == 0) begin
            m_phase = 2;
          end else begin
            for (int i = 0; i < int'(length); i++) addr_q.push_back((int'(start_addr) + i) % DEPTH);
            m_data  = m_mem[addr_q.pop_front()];
            m_vaild = 1'b1;
            m_phase = 1;
          end
        end
        1: if (ready) begin
          if (addr_q.size() > 0) m_data = m_mem[addr_q.pop_front()];
          else begin
            m_vaild = 1'b0;
            m_phase = 2;
          end
        end else if (m_stall < 65535) begin
          m_stall++;
        end
        default: m_phase = 0;
      endcase
      if (wr_en) m_mem[wr_addr] = wr_data;
    end
  endtask

  // one clock: log handshake, advance model, compare all outputs after the edge
  task automatic tick();
    if (vaild && ready && !s_rst) xlog.push_back(data_out);
    @(posedge clk);
    model_edge();
    #1;
    check_eq("vaild", 32'(vaild), 32'(m_vaild));
    check_eq("data_out", 32'(data_out), 32'(m_data));
    check_eq("busy", 32'(busy), 32'(m_phase != 0));
    check_eq("done", 32'(done), 32'(m_phase == 2));
`ifdef SOURCE_V3_STALL_CNT_EN
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_stall));
`endif
  endtask

  task automatic cyc(input logic we, input int wa, input int wd, input logic st,
                     input int sa, input int len, input logic rdy);
    wr_en      = we;
    wr_addr    = WT'(wa);
    wr_data    = WIDTH'(wd);
    start      = st;
    start_addr = WT'(sa);
    length     = (WT + 1)'(len);
    ready      = rdy;
    tick();
  endtask

  task automatic check_log(input string tag, input int n, input int e0, input int e1,
                           input int e2, input int e3);
    int exp[4];
    exp = '{e0, e1, e2, e3};
    check_eq({tag, "_count"}, 32'(xlog.size()), 32'(n));
    for (int i = 0; i < n && i < xlog.size(); i++)
      check_eq({tag, "_word"}, 32'(xlog[i]), 32'(exp[i]));
    xlog.delete();
  endtask

  initial begin
    // reset
    s_rst = 1'b1;
    cyc(1'b1, 5, 8'h99, 1'b1, 0, 3, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    check_eq("rst_vaild", 32'(vaild), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    s_rst = 1'b0;

    // basic 4-word burst at full rate
    cyc(1'b1, 0, 8'h11, 1'b0, 0, 0, 1'b1);
    cyc(1'b1, 1, 8'h22, 1'b0, 0, 0, 1'b1);
    cyc(1'b1, 2, 8'h33, 1'b0, 0, 0, 1'b1);
    cyc(1'b1, 3, 8'h44, 1'b0, 0, 0, 1'b1);
    xlog.delete();
    cyc(1'b0, 0, 0, 1'b1, 0, 4, 1'b1);
    repeat (6) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    check_log("burst4", 4, 8'h11, 8'h22, 8'h33, 8'h44);

    // same burst with back-pressure
    cyc(1'b0, 0, 0, 1'b1, 0, 4, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    repeat (3) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    check_log("stall_burst", 4, 8'h11, 8'h22, 8'h33, 8'h44);
`ifdef SOURCE_V3_STALL_CNT_EN
    check_eq("stall_total", 32'(stall_cnt), 32'd3);
`endif

    // writes during a burst: current word, same-cycle fetch, not-yet-fetched word
    cyc(1'b0, 0, 0, 1'b1, 0, 4, 1'b0);
    cyc(1'b1, 0, 8'h55, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 2, 8'h66, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 1, 8'h77, 1'b0, 0, 0, 1'b1);
    repeat (5) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    check_log("wr_hazard", 4, 8'h11, 8'h22, 8'h66, 8'h44);

    // address wrap
    cyc(1'b1, 254, 8'hA0, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 255, 8'hA1, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 0, 8'hA2, 1'b0, 0, 0, 1'b0);
    cyc(1'b1, 1, 8'hA3, 1'b0, 0, 0, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, DEPTH - 2, 4, 1'b1);
    repeat (6) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    check_log("wrap", 4, 8'hA0, 8'hA1, 8'hA2, 8'hA3);

    // zero-length start, then start ignored during SEND
    cyc(1'b0, 0, 0, 1'b1, 0, 0, 1'b1);
    check_eq("len0_vaild", 32'(vaild), 32'd0);
    check_eq("len0_done", 32'(done), 32'd1);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b1, 254, 4, 1'b0);
    cyc(1'b0, 0, 0, 1'b1, 0, 2, 1'b1);
    repeat (6) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    check_log("start_ign", 4, 8'hA0, 8'hA1, 8'hA2, 8'hA3);

    // reset mid-burst after two transfers
    cyc(1'b0, 0, 0, 1'b1, 0, 4, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    s_rst = 1'b1;
    cyc(1'b1, 0, 8'hEE, 1'b1, 0, 4, 1'b0);
    s_rst = 1'b0;
    check_eq("abort_vaild", 32'(vaild), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd0);
    xlog.delete();
    cyc(1'b0, 0, 0, 1'b1, 0, 2, 1'b1);
    repeat (4) cyc(1'b0, 0, 0, 1'b0, 0, 0, 1'b1);
    check_log("post_rst", 2, 0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      s_rst = ($urandom_range(0, 299) == 0);
      cyc(($urandom_range(0, 9) < 3), $urandom_range(0, DEPTH - 1), $urandom_range(0, 255),
          ($urandom_range(0, 9) == 0), $urandom_range(0, DEPTH - 1),
          ($urandom_range(0, 19) == 0) ? DEPTH : $urandom_range(0, 6),
          ($urandom_range(0, 9) < 7));
    end
    s_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
